circulant_column_reader: RTL and testbench
==========================================

Name: circulant_column_reader

Overview:
- Read-side sequencer for a circulant-skewed transpose buffer.
- Storage: MATRIX_DIM single-port banks, COL_WIDTH wide, MATRIX_DIM deep. Element (r,c) lives in bank (r+c) mod MATRIX_DIM at address r.
- On start, the block reads whole matrix columns 0..MATRIX_DIM-1, one column per bank access. It de-rotates the bank outputs into row order and streams each column as one wide word over a valid/ready interface with backpressure.
- It sits between the bank array and the downstream column consumer.

Parameters:
- MATRIX_DIM, 4, square matrix dimension; must be a power of 2 and at least 2.
- COL_WIDTH, 8, element width in bits; also the bank data width.
- ADDR_LEN, $clog2(MATRIX_DIM), bank address, row index and column index width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to transpose-read the full matrix.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last column is accepted downstream.
- bank_rd_en  out  1  read strobe, common to all banks.
- bank_rd_addr  out  MATRIX_DIM*ADDR_LEN  per-bank address; bank b at [b*ADDR_LEN +: ADDR_LEN].
- bank_rd_data  in  MATRIX_DIM*COL_WIDTH  bank outputs; bank b at [b*COL_WIDTH +: COL_WIDTH]. Valid exactly 1 cycle after bank_rd_en.
- out_valid  out  1  out_data, out_col and out_last are valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  MATRIX_DIM*COL_WIDTH  one column; row r at [r*COL_WIDTH +: COL_WIDTH].
- out_col  out  ADDR_LEN  column index of out_data.
- out_last  out  1  high with column MATRIX_DIM-1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; busy, done, bank_rd_en and out_valid go to 0.
  - bank_rd_addr, out_data, out_col and out_last go to 0.
  - The skid FIFO is emptied and any in-flight read is discarded.
  - Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches issue column ic=0, moves to RUN and sets busy=1 next cycle.
  - RUN: issues columns; after issuing column MATRIX_DIM-1, moves to DRAIN.
  - DRAIN: when the final word (out_last) is accepted, moves to IDLE, pulses done=1 for one cycle and clears busy the same cycle.
  - start is ignored while busy or done is high.
- Issue, in RUN:
  - bank_rd_en=1 when (fifo_count + inflight − pop) < 2, where pop = out_valid && out_ready in the same cycle.
  - On issue, bank b address = (b − ic) & (MATRIX_DIM−1), then ic increments.
  - Addresses are registered outputs presented in the issue cycle; bank_rd_addr holds its last value when not issuing.
- Capture: the cycle after an issue, lane r of the FIFO entry = bank ((r + col) & (MATRIX_DIM−1)) of bank_rd_data. col and last (col == MATRIX_DIM−1) are stored alongside.
- Skid FIFO:
  - 2 entries; out_valid = fifo not empty; outputs driven from the head.
  - Simultaneous push and pop allowed; overflow is impossible by the issue rule.
- Latency and throughput:
  - start sampled at edge k → first bank_rd_en in cycle k+1 → first out_valid in cycle k+3.
  - With out_ready held high: one column per cycle, done in cycle k+3+MATRIX_DIM.
- Backpressure: while out_ready=0, output fields stay stable and issue stalls at most 2 columns ahead. No column is lost or duplicated.
- All index arithmetic is modulo MATRIX_DIM, using ADDR_LEN-bit wrap.

Test Plan:
- Fill a bank model, N=4, W=8, with element (r,c) = {r[3:0],c[3:0]}; pulse start, out_ready=1. Expected out_data sequence: 0x30201000, 0x31211101, 0x32221202, 0x33231303. out_col 0..3, out_last only on col 3, done one cycle after the col-3 handshake.
- Address check, column 1 issue cycle → bank_rd_addr = 8'h93 (banks 3..0 = 2,1,0,3).
- Backpressure: out_ready=0 for cycles k+3..k+8. Expected: at most 2 bank_rd_en issued; out_data stays 0x30201000; all 4 columns delivered in order after release.
- Alternating out_ready 1/0 each cycle → 4 correct columns, no duplicates, done exactly once.
- Reset: rst_n=0 for one cycle after column 1 is accepted → all outputs 0 and no done. A new start then yields the full sequence from col 0.
- start pulsed again while busy → ignored; exactly 4 columns and 1 done.

Source files
------------

// File: rtl/circulant_column_reader.sv
// Read sequencer for a circulant-skewed transpose buffer: walks the columns, de-rotates
// the bank outputs into row order and streams one column per word through a 2-entry skid FIFO.
module circulant_column_reader #(
    parameter int MATRIX_DIM = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_LEN   = $clog2(MATRIX_DIM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            bank_rd_en,
    output logic [MATRIX_DIM*ADDR_LEN-1:0]  bank_rd_addr,
    input  logic [MATRIX_DIM*COL_WIDTH-1:0] bank_rd_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MATRIX_DIM*COL_WIDTH-1:0] out_data,
    output logic [ADDR_LEN-1:0]             out_col,
    output logic                            out_last
);

    localparam int DATA_W = MATRIX_DIM * COL_WIDTH;
    localparam int ADDR_W = MATRIX_DIM * ADDR_LEN;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [ADDR_LEN-1:0] ic_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                inflight_q;
    logic [ADDR_LEN-1:0] cap_col_q;

    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [ADDR_LEN-1:0] fifo_col_q  [2];
    logic                fifo_last_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;

    logic                pop;
    logic [2:0]          occupancy;
    logic                issue;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   lane_d;
    logic [ADDR_LEN-1:0] src;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;

    // Slots already committed after this edge; a new issue lands one cycle later.
    assign occupancy = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue     = (state_q == RUN) && (occupancy < 3'd2);

    assign bank_rd_en   = issue;
    assign bank_rd_addr = issue ? addr_d : addr_q;

    always_comb begin
        addr_d = '0;
        for (int b = 0; b < MATRIX_DIM; b++) begin
            addr_d[b*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(b) - ic_q;
        end
    end

    // Row r of the captured column sits in bank (r + col), wrapping at ADDR_LEN bits.
    always_comb begin
        lane_d = '0;
        src    = '0;
        for (int r = 0; r < MATRIX_DIM; r++) begin
            src = ADDR_LEN'(r) + cap_col_q;
            lane_d[r*COL_WIDTH +: COL_WIDTH] = bank_rd_data[int'(src)*COL_WIDTH +: COL_WIDTH];
        end
    end

    assign out_data = fifo_data_q[rd_ptr_q];
    assign out_col  = fifo_col_q[rd_ptr_q];
    assign out_last = fifo_last_q[rd_ptr_q];
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ic_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            cap_col_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_col_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;

            case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        ic_q    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q    <= addr_d;
                        cap_col_q <= ic_q;
                        ic_q      <= ic_q + 1'b1;
                        if (ic_q == ADDR_LEN'(MATRIX_DIM - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= lane_d;
                fifo_col_q[wr_ptr_q]  <= cap_col_q;
                fifo_last_q[wr_ptr_q] <= (cap_col_q == ADDR_LEN'(MATRIX_DIM - 1));
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_circulant_column_reader.sv
// Directed bench for circulant_column_reader: bank model filled with {row,col} elements,
// per-scenario tasks checking column order, latency, addressing, backpressure and reset.
module tb_circulant_column_reader;

    localparam int N = 4;
    localparam int W = 8;
    localparam int A = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           done;
    logic           bank_rd_en;
    logic [N*A-1:0] bank_rd_addr;
    logic [N*W-1:0] bank_rd_data;
    logic           out_valid;
    logic [N*W-1:0] out_data;
    logic [A-1:0]   out_col;
    logic           out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0]   bankMem [N][N];

    logic [N*W-1:0] hsData [$];
    logic [A-1:0]   hsCol [$];
    logic           hsLast [$];
    logic [N*A-1:0] issueAddr [$];
    int             firstIssueCyc;
    int             firstValidCyc;
    int             doneCyc;
    int             doneCount;

    circulant_column_reader #(.MATRIX_DIM(N), .COL_WIDTH(W), .ADDR_LEN(A)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bank_rd_en   (bank_rd_en),
        .bank_rd_addr (bank_rd_addr),
        .bank_rd_data (bank_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_col      (out_col),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Banks return data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bank_rd_en) begin
            for (int b = 0; b < N; b++) begin
                bank_rd_data[b*W +: W] <= bankMem[b][bank_rd_addr[b*A +: A]];
            end
        end
    end

    always @(negedge clk) begin
        if (bank_rd_en) begin
            issueAddr.push_back(bank_rd_addr);
            if (firstIssueCyc < 0) firstIssueCyc = cyc;
        end
        if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
        if (out_valid && out_ready) begin
            hsData.push_back(out_data);
            hsCol.push_back(out_col);
            hsLast.push_back(out_last);
        end
        if (done) begin
            doneCount++;
            if (doneCyc < 0) doneCyc = cyc;
        end
    end

    function automatic logic [N*W-1:0] expWord(input int c);
        logic [N*W-1:0] w;
        w = '0;
        for (int r = 0; r < N; r++) begin
            w[r*W +: W] = 8'(r * 16 + c);
        end
        return w;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        hsData.delete();
        hsCol.delete();
        hsLast.delete();
        issueAddr.delete();
        firstIssueCyc = -1;
        firstValidCyc = -1;
        doneCyc = -1;
        doneCount = 0;
    endtask

    task automatic waitDone(input int maxCyc);
        int n;
        n = 0;
        while (doneCount == 0 && n < maxCyc) begin
            nextCycle();
            n++;
        end
    endtask

    task automatic pulseStart(output int p);
        nextCycle();
        start = 1'b1;
        p = cyc;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) nextCycle();
        @(negedge clk);
        checks++;
        if ({busy, done, bank_rd_en, out_valid, out_last, bank_rd_addr, out_data, out_col} !== '0)
            begin
            errors++;
            $display("[TB] FAIL reset_outputs busy=%b done=%b en=%b valid=%b addr=%h data=%h col=%0d last=%b, expected all 0",
                     busy, done, bank_rd_en, out_valid, bank_rd_addr, out_data, out_col, out_last);
        end
        nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int p;
        clearMon();
        out_ready = 1'b1;
        pulseStart(p);
        waitDone(30);
        repeat (3) nextCycle();
        checks++;
        if (hsData.size() !== 4) begin
            errors++;
            $display("[TB] FAIL stream_count got %0d expected 4", hsData.size());
        end
        for (int i = 0; i < hsData.size() && i < 4; i++) begin
            checks++;
            if ({hsCol[i], hsLast[i], hsData[i]} !== {2'(i), (i == 3), expWord(i)}) begin
                errors++;
                $display("[TB] FAIL stream_col%0d got col=%0d last=%b data=%h expected col=%0d last=%b data=%h",
                         i, hsCol[i], hsLast[i], hsData[i], i, (i == 3), expWord(i));
            end
        end
        checks++;
        if (firstIssueCyc !== p + 1) begin
            errors++;
            $display("[TB] FAIL first_issue_latency got %0d expected %0d", firstIssueCyc - p, 1);
        end
        checks++;
        if (firstValidCyc !== p + 3) begin
            errors++;
            $display("[TB] FAIL first_valid_latency got %0d expected %0d", firstValidCyc - p, 3);
        end
        checks++;
        if (doneCyc !== p + 3 + N || doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL stream_done latency=%0d count=%0d expected latency=%0d count=1",
                     doneCyc - p, doneCount, 3 + N);
        end
        checks++;
        if (issueAddr.size() !== 4 || issueAddr[0] !== 8'hE4 || issueAddr[1] !== 8'h93) begin
            errors++;
            $display("[TB] FAIL issue_addr issues=%0d col0=%h col1=%h expected issues=4 col0=e4 col1=93",
                     issueAddr.size(), (issueAddr.size() > 0) ? issueAddr[0] : 8'hxx,
                     (issueAddr.size() > 1) ? issueAddr[1] : 8'hxx);
        end
        @(negedge clk);
        checks++;
        if (bank_rd_addr !== 8'h39 || busy !== 1'b0 || bank_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold addr=%h busy=%b en=%b expected addr=39 busy=0 en=0",
                     bank_rd_addr, busy, bank_rd_en);
        end
    endtask

    task automatic test_backpressure();
        int p;
        clearMon();
        out_ready = 1'b0;
        pulseStart(p);
        for (int i = 2; i <= 8; i++) begin
            nextCycle();
            if (i >= 3) begin
                @(negedge clk);
                checks++;
                if ({out_valid, out_col, out_data} !== {1'b1, 2'd0, expWord(0)}) begin
                    errors++;
                    $display("[TB] FAIL bp_hold_k%0d got valid=%b col=%0d data=%h expected valid=1 col=0 data=%h",
                             i, out_valid, out_col, out_data, expWord(0));
                end
            end
        end
        #1;
        checks++;
        if (issueAddr.size() !== 2) begin
            errors++;
            $display("[TB] FAIL bp_issue_count got %0d expected 2", issueAddr.size());
        end
        nextCycle();
        out_ready = 1'b1;
        waitDone(30);
        repeat (2) nextCycle();
        checks++;
        if (hsData.size() !== 4 || doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL bp_totals cols=%0d done=%0d expected cols=4 done=1", hsData.size(), doneCount);
        end
        for (int i = 0; i < hsData.size() && i < 4; i++) begin
            checks++;
            if ({hsCol[i], hsLast[i], hsData[i]} !== {2'(i), (i == 3), expWord(i)}) begin
                errors++;
                $display("[TB] FAIL bp_col%0d got col=%0d last=%b data=%h expected col=%0d data=%h",
                         i, hsCol[i], hsLast[i], hsData[i], i, expWord(i));
            end
        end
    endtask

    task automatic test_alternating();
        int p;
        int n;
        clearMon();
        out_ready = 1'b1;
        pulseStart(p);
        n = 0;
        while (doneCount == 0 && n < 60) begin
            nextCycle();
            out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        repeat (6) nextCycle();
        checks++;
        if (hsData.size() !== 4 || doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL alt_totals cols=%0d done=%0d expected cols=4 done=1", hsData.size(), doneCount);
        end
        for (int i = 0; i < hsData.size() && i < 4; i++) begin
            checks++;
            if ({hsCol[i], hsLast[i], hsData[i]} !== {2'(i), (i == 3), expWord(i)}) begin
                errors++;
                $display("[TB] FAIL alt_col%0d got col=%0d last=%b data=%h expected col=%0d data=%h",
                         i, hsCol[i], hsLast[i], hsData[i], i, expWord(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int p;
        int n;
        clearMon();
        out_ready = 1'b1;
        pulseStart(p);
        n = 0;
        while (hsData.size() < 2 && n < 30) begin
            nextCycle();
            n++;
        end
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, bank_rd_en, out_valid, out_last, bank_rd_addr, out_data, out_col} !== '0)
            begin
            errors++;
            $display("[TB] FAIL midreset_outputs busy=%b done=%b en=%b valid=%b addr=%h data=%h col=%0d last=%b, expected all 0",
                     busy, done, bank_rd_en, out_valid, bank_rd_addr, out_data, out_col, out_last);
        end
        repeat (10) nextCycle();
        checks++;
        if (doneCount !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done got %0d expected 0", doneCount);
        end
        clearMon();
        pulseStart(p);
        waitDone(30);
        repeat (2) nextCycle();
        checks++;
        if (hsData.size() !== 4 || doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL restart_totals cols=%0d done=%0d expected cols=4 done=1", hsData.size(), doneCount);
        end
        for (int i = 0; i < hsData.size() && i < 4; i++) begin
            checks++;
            if ({hsCol[i], hsLast[i], hsData[i]} !== {2'(i), (i == 3), expWord(i)}) begin
                errors++;
                $display("[TB] FAIL restart_col%0d got col=%0d data=%h expected col=%0d data=%h",
                         i, hsCol[i], hsData[i], i, expWord(i));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int p;
        clearMon();
        out_ready = 1'b1;
        pulseStart(p);
        // Extra start pulses land mid-run and on the done cycle (p+7).
        for (int i = 2; i <= 12; i++) begin
            nextCycle();
            start = (i == 3 || i == 7);
        end
        nextCycle();
        start = 1'b0;
        repeat (5) nextCycle();
        checks++;
        if (hsData.size() !== 4 || doneCount !== 1 || issueAddr.size() !== 4) begin
            errors++;
            $display("[TB] FAIL busy_start cols=%0d done=%0d issues=%0d expected 4/1/4",
                     hsData.size(), doneCount, issueAddr.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_idle busy=%b expected 0", busy);
        end
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                bankMem[(r + c) % N][r] = 8'(r * 16 + c);
            end
        end
        clearMon();
        test_reset();
        test_stream();
        test_backpressure();
        test_alternating();
        test_reset_mid();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
